// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg: encodings shared by the writeback stage and its helpers
package writeback_stage_pkg;
    localparam logic [1:0] WB_SRC_MEM  = 2'd0;
    localparam logic [1:0] WB_SRC_ALU  = 2'd1;
    localparam logic [1:0] WB_SRC_LINK = 2'd2;
    localparam logic [1:0] DST_RT   = 2'd0;
    localparam logic [1:0] DST_RD   = 2'd1;
    localparam logic [1:0] DST_ZERO = 2'd2;
    localparam logic [1:0] DST_LINK = 2'd3;
    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;
endpackage

// File: rtl/writeback_stage_load_extender.sv
// load_extender: little-endian sub-word lane extraction with sign or zero extension
module load_extender
    import writeback_stage_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic [NBITS-1:0] word,
    input  logic [1:0]       lsb,
    input  logic [1:0]       size,
    input  logic             is_unsigned,
    output logic [NBITS-1:0] data
);
    logic [7:0]       b;
    logic [15:0]      h;
    logic [NBITS-1:0] eb;
    logic [NBITS-1:0] eh;
    assign b = word[{lsb, 3'b000} +: 8];
    // Misaligned halves drop lsb[0] and read the containing aligned half.
    assign h = word[{lsb[1], 4'b0000} +: 16];
    mux2 #(.W(NBITS)) u_byte (
        .in0({{(NBITS-8){b[7]}}, b}),
        .in1({{(NBITS-8){1'b0}}, b}),
        .sel(is_unsigned),
        .out(eb)
    );
    mux2 #(.W(NBITS)) u_half (
        .in0({{(NBITS-16){h[15]}}, h}),
        .in1({{(NBITS-16){1'b0}}, h}),
        .sel(is_unsigned),
        .out(eh)
    );
    assign data = size == MEM_BYTE ? eb : size == MEM_HALF ? eh : word;
endmodule

// File: rtl/writeback_stage_mux.sv
// writeback_stage_mux: generic 2- and 4-input multiplexers
module mux2 #(
    parameter int W = 32
) (
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic         sel,
    output logic [W-1:0] out
);
    assign out = sel ? in1 : in0;
endmodule

module mux4 #(
    parameter int W = 32
) (
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    input  logic [1:0]   sel,
    output logic [W-1:0] out
);
    assign out = sel[1] ? (sel[0] ? in3 : in2) : (sel[0] ? in1 : in0);
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB register plus writeback source/destination select and retire counter
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int NBITS     = 32,
    parameter int NREG_BITS = 5,
    parameter int LINK_REG  = 31,
    parameter int CNT_BITS  = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  logic                 i_valid,
    input  logic [NBITS-1:0]     i_ALU_rslt,
    input  logic [NBITS-1:0]     i_data,
    input  logic [NBITS-1:0]     i_pc_link,
    input  logic [1:0]           i_addr_lsb,
    input  logic [1:0]           i_flg_mem_size,
    input  logic                 i_flg_unsigned,
    input  logic [1:0]           i_flg_wb_src,
    input  logic [1:0]           i_flg_ALU_dst,
    input  logic [NREG_BITS-1:0] i_rd,
    input  logic [NREG_BITS-1:0] i_rt,
    input  logic                 i_flg_reg_wr_en,
    output logic [NBITS-1:0]     o_wr_data,
    output logic [NREG_BITS-1:0] o_reg_sel,
    output logic                 o_wr_en,
    output logic                 o_valid,
    output logic [CNT_BITS-1:0]  o_retired_cnt
);
    localparam logic [NREG_BITS-1:0] LINK_IDX = NREG_BITS'(LINK_REG);
    logic [NBITS-1:0]     ld_data;
    logic [NBITS-1:0]     wb_data;
    logic [NREG_BITS-1:0] dst;
    logic                 held;
    logic                 load;
    load_extender #(.NBITS(NBITS)) u_ext (
        .word(i_data),
        .lsb(i_addr_lsb),
        .size(i_flg_mem_size),
        .is_unsigned(i_flg_unsigned),
        .data(ld_data)
    );
    mux4 #(.W(NBITS)) u_src (
        .in0(ld_data),
        .in1(i_ALU_rslt),
        .in2(i_pc_link),
        .in3(i_ALU_rslt),
        .sel(i_flg_wb_src),
        .out(wb_data)
    );
    mux4 #(.W(NREG_BITS)) u_dst (
        .in0(i_rt),
        .in1(i_rd),
        .in2('0),
        .in3(LINK_IDX),
        .sel(i_flg_ALU_dst),
        .out(dst)
    );
    assign held = i_stall & ~i_flush;
    assign load = ~i_flush & i_valid;
    // Bubbles and flushes keep the old data/index; only valid and strobe drop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_wr_data     <= '0;
            o_reg_sel     <= '0;
            o_wr_en       <= 1'b0;
            o_valid       <= 1'b0;
            o_retired_cnt <= '0;
        end else if (!held) begin
            o_valid       <= load;
            o_wr_en       <= load & i_flg_reg_wr_en & (dst != '0);
            o_retired_cnt <= o_retired_cnt + CNT_BITS'(o_valid);
            if (load) begin
                o_wr_data <= wb_data;
                o_reg_sel <= dst;
            end
        end
    end
endmodule
